// File: rtl/cmd_queue_mc.sv
// Multi-producer command queue: round-robin admission of N_CH valid/ready ports into a shared FWFT store.
// Optional occupancy/stall statistics are compiled in with `define CMDQ_STATS_EN.
module cmd_queue_mc #(
    parameter int WIDTH    = 64,
    parameter int DEPTH    = 128,
    parameter int N_CH     = 3,
    parameter int AFULL_TH = DEPTH - 4,
    localparam int AW      = $clog2(DEPTH),
    localparam int CW      = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int CNTW    = AW + 1
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [N_CH-1:0]       i_wr_valid,
    input  logic [N_CH*WIDTH-1:0] i_wr_data,
    output logic [N_CH-1:0]       o_wr_ready,
    input  logic                  i_read,
    input  logic                  i_flush,
    output logic [WIDTH-1:0]      o_data,
    output logic [CW-1:0]         o_ch,
    output logic                  o_fifo_empty,
    output logic                  o_almost_full,
    output logic [CNTW-1:0]       o_count
`ifdef CMDQ_STATS_EN
    ,
    output logic [CNTW-1:0]       o_hwm,
    output logic [N_CH*16-1:0]    o_stall_cnt
`endif
);

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [CW-1:0]    mem_ch   [DEPTH];

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CNTW-1:0]  count;
    logic [CNTW-1:0]  count_nxt;
    logic [CW-1:0]    rr_ptr;
    logic [CW-1:0]    rr_nxt;

    logic             gnt_vld;
    logic [CW-1:0]    gnt_ch;
    logic [WIDTH-1:0] wr_data_sel;
    logic             full;
    logic             wr_en;
    logic             rd_en;

    assign full          = (count == CNTW'(DEPTH));
    assign o_fifo_empty  = (count == '0);
    assign o_almost_full = (count >= CNTW'(AFULL_TH));
    assign o_count       = count;
    assign o_data        = mem_data[rd_ptr];
    assign o_ch          = mem_ch[rd_ptr];

    // Second pass overrides the wrap-around winner with the lowest requester at or above rr_ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (i_wr_valid[c]) begin
                gnt_vld = 1'b1;
                gnt_ch  = CW'(c);
            end
        end
        for (int c = N_CH - 1; c >= 0; c--) begin
            if (i_wr_valid[c] && (c >= int'(rr_ptr))) begin
                gnt_ch = CW'(c);
            end
        end
    end

    // Ready never looks at i_read, so a full queue stalls producers for one extra cycle.
    always_comb begin
        o_wr_ready = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_wr_ready[c] = gnt_vld && (gnt_ch == CW'(c)) && !full && !i_flush && i_rstn;
        end
    end

    always_comb begin
        wr_data_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (gnt_ch == CW'(c)) begin
                wr_data_sel = i_wr_data[c*WIDTH +: WIDTH];
            end
        end
    end

    assign wr_en  = |o_wr_ready;
    assign rd_en  = i_read && !o_fifo_empty && !i_flush;
    assign rr_nxt = (gnt_ch == CW'(N_CH - 1)) ? '0 : gnt_ch + CW'(1);

    always_comb begin
        count_nxt = count;
        if (i_flush) begin
            count_nxt = '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   count_nxt = count + CNTW'(1);
                2'b01:   count_nxt = count - CNTW'(1);
                default: count_nxt = count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rr_ptr <= '0;
        end else begin
            count <= count_nxt;
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_en) begin
                    wr_ptr <= wr_ptr + AW'(1);
                    rr_ptr <= rr_nxt;
                end
                if (rd_en) begin
                    rd_ptr <= rd_ptr + AW'(1);
                end
            end
        end
    end

    // Storage carries no reset; entries are only observed once count says they exist.
    always_ff @(posedge i_clk) begin
        if (wr_en) begin
            mem_data[wr_ptr] <= wr_data_sel;
            mem_ch[wr_ptr]   <= gnt_ch;
        end
    end

`ifdef CMDQ_STATS_EN
    logic [CNTW-1:0] hwm;
    logic [15:0]     stall_cnt [N_CH];

    // Tracking the next count keeps o_hwm >= o_count on every cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rstn || i_flush) begin
            hwm <= '0;
        end else if (count_nxt > hwm) begin
            hwm <= count_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        for (int c = 0; c < N_CH; c++) begin
            if (!i_rstn) begin
                stall_cnt[c] <= '0;
            end else if (i_wr_valid[c] && !o_wr_ready[c] && (stall_cnt[c] != 16'hFFFF)) begin
                stall_cnt[c] <= stall_cnt[c] + 16'd1;
            end
        end
    end

    always_comb begin
        o_stall_cnt = '0;
        for (int c = 0; c < N_CH; c++) begin
            o_stall_cnt[c*16 +: 16] = stall_cnt[c];
        end
    end

    assign o_hwm = hwm;
`endif

endmodule

// File: tb/tb_cmd_queue_mc.sv
// Bench for cmd_queue_mc: queue-based reference model compared every cycle, directed scenarios, then random traffic.
module tb_cmd_queue_mc;

    localparam int WIDTH    = 16;
    localparam int DEPTH    = 8;
    localparam int N_CH     = 3;
    localparam int AFULL_TH = DEPTH - 4;
    localparam int CW       = 2;
    localparam int CNTW     = 4;

    logic                  clk = 1'b0;
    logic                  rstn;
    logic                  read;
    logic                  flush;
    logic [N_CH-1:0]       wr_valid;
    logic [N_CH-1:0]       wr_ready;
    logic [N_CH*WIDTH-1:0] wr_data;
    logic [WIDTH-1:0]      dout;
    logic [CW-1:0]         ch;
    logic                  empty;
    logic                  afull;
    logic [CNTW-1:0]       count;
`ifdef CMDQ_STATS_EN
    logic [CNTW-1:0]       hwm;
    logic [N_CH*16-1:0]    stall_cnt;
`endif

    always #5 clk = ~clk;

    cmd_queue_mc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .N_CH(N_CH)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_wr_valid   (wr_valid),
        .i_wr_data    (wr_data),
        .o_wr_ready   (wr_ready),
        .i_read       (read),
        .i_flush      (flush),
        .o_data       (dout),
        .o_ch         (ch),
        .o_fifo_empty (empty),
        .o_almost_full(afull),
        .o_count      (count)
`ifdef CMDQ_STATS_EN
        ,
        .o_hwm        (hwm),
        .o_stall_cnt  (stall_cnt)
`endif
    );

    int errors = 0;
    int checks = 0;
    bit checking = 1'b0;

    typedef struct {
        int               ch;
        logic [WIDTH-1:0] data;
    } ent_t;

    ent_t            mq[$];
    int              m_rr = 0;
    int              m_hwm = 0;
    int              m_stall[N_CH];
    logic [N_CH-1:0] m_rdy;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin scan starting at the model's rr, only when the queue has room.
    function automatic logic [N_CH-1:0] exp_ready();
        logic [N_CH-1:0] r;
        r = '0;
        if (rstn === 1'b1 && flush === 1'b0 && mq.size() < DEPTH) begin
            for (int k = 0; k < N_CH; k++) begin
                int c;
                c = (m_rr + k) % N_CH;
                if (|(wr_valid & (N_CH'(1) << c))) begin
                    r = N_CH'(1) << c;
                    break;
                end
            end
        end
        return r;
    endfunction

    always @(posedge clk) begin
        m_rdy = exp_ready();
        if (rstn !== 1'b1) begin
            mq.delete();
            m_rr  = 0;
            m_hwm = 0;
            for (int c = 0; c < N_CH; c++) m_stall[c] = 0;
        end else begin
            for (int c = 0; c < N_CH; c++)
                if (((wr_valid >> c) & 1) != 0 && ((m_rdy >> c) & 1) == 0 && m_stall[c] < 65535)
                    m_stall[c]++;
            if (flush) begin
                mq.delete();
                m_hwm = 0;
            end else begin
                if (read && mq.size() > 0) void'(mq.pop_front());
                for (int c = 0; c < N_CH; c++) begin
                    if (((m_rdy >> c) & 1) != 0) begin
                        mq.push_back('{c, wr_data[c*WIDTH +: WIDTH]});
                        m_rr = (c + 1) % N_CH;
                    end
                end
                if (mq.size() > m_hwm) m_hwm = mq.size();
            end
        end
    end

    always @(negedge clk) begin
        if (checking) begin
            chk("empty", empty, mq.size() == 0);
            chk("count", count, mq.size());
            chk("afull", afull, mq.size() >= AFULL_TH);
            chk("ready", wr_ready, exp_ready());
            if (mq.size() > 0) begin
                chk("data", dout, mq[0].data);
                chk("ch", ch, mq[0].ch);
            end
`ifdef CMDQ_STATS_EN
            chk("hwm", hwm, m_hwm);
            for (int c = 0; c < N_CH; c++) chk("stall", stall_cnt[c*16 +: 16], m_stall[c]);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [WIDTH-1:0] exp_d [6] = '{16'h0000, 16'h0101, 16'h0202, 16'h0003, 16'h0104, 16'h0205};
    int               exp_c [6] = '{0, 1, 2, 0, 1, 2};

    initial begin
        rstn = 1'b0; read = 1'b0; flush = 1'b0; wr_valid = '0; wr_data = '0;
        cyc();
        checking = 1'b1;
        wr_valid = 3'b111;
        #1;
        chk("rst_ready", wr_ready, 3'b000);
        chk("rst_empty", empty, 1'b1);
        chk("rst_count", count, 0);
        chk("rst_afull", afull, 1'b0);
        cyc();
        wr_valid = '0;
        rstn = 1'b1;

        // single write then pop
        wr_valid = 3'b001;
        wr_data[15:0] = 16'h00A5;
        #1;
        chk("t1_nobypass", empty, 1'b1);
        chk("t1_ready", wr_ready, 3'b001);
        cyc();
        wr_valid = '0;
        chk("t1_empty", empty, 1'b0);
        chk("t1_data", dout, 16'h00A5);
        chk("t1_ch", ch, 0);
        read = 1'b1;
        cyc();
        read = 1'b0;
        chk("t1_pop_empty", empty, 1'b1);
        chk("t1_pop_count", count, 0);

        // round-robin order with all channels requesting
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        for (int k = 0; k < 6; k++) begin
            wr_valid = 3'b111;
            for (int c = 0; c < N_CH; c++) wr_data[c*WIDTH +: WIDTH] = WIDTH'(16'h100 * c + k);
            cyc();
        end
        wr_valid = '0;
        chk("t2_count", count, 6);
        chk("t2_afull", afull, 1'b1);
        for (int k = 0; k < 6; k++) begin
            chk("t2_ch", ch, exp_c[k]);
            chk("t2_data", dout, exp_d[k]);
            read = 1'b1;
            cyc();
            read = 1'b0;
        end
        chk("t2_empty", empty, 1'b1);

        // fill from channel 1, full-cycle read does not admit a write
        for (int k = 0; k < 8; k++) begin
            wr_valid = 3'b010;
            wr_data[WIDTH +: WIDTH] = WIDTH'(k);
            #1;
            chk("t3_afull", afull, k >= 4);
            cyc();
        end
        wr_valid = 3'b010;
        wr_data[WIDTH +: WIDTH] = 16'd8;
        #1;
        chk("t3_full_count", count, 8);
        chk("t3_full_ready", wr_ready, 3'b000);
        read = 1'b1;
        #1;
        chk("t3_full_rd_ready", wr_ready, 3'b000);
        cyc();
        read = 1'b0;
        chk("t3_after_pop", count, 7);
        #1;
        chk("t3_ready_next", wr_ready, 3'b010);
        cyc();
        wr_valid = '0;
        chk("t3_refill", count, 8);
        chk("t3_head", dout, 16'd1);

        // steady read+write at count 5 across pointer wrap
        read = 1'b1;
        repeat (3) cyc();
        read = 1'b0;
        chk("t4_count", count, 5);
        chk("t4_head", dout, 16'd4);
        for (int k = 0; k < 20; k++) begin
            wr_valid = 3'b010;
            wr_data[WIDTH +: WIDTH] = WIDTH'(100 + k);
            read = 1'b1;
            cyc();
            chk("t4_steady", count, 5);
        end
        read = 1'b0;
        wr_valid = '0;
        chk("t4_head_end", dout, 16'd115);

        // flush with concurrent read/write; rr survives
        wr_valid = 3'b001;
        wr_data[15:0] = 16'h0055;
        cyc();
        wr_valid = '0;
        chk("t5_count", count, 6);
        flush = 1'b1; read = 1'b1; wr_valid = 3'b111;
        #1;
        chk("t5_flush_ready", wr_ready, 3'b000);
        cyc();
        flush = 1'b0; read = 1'b0; wr_valid = '0;
        chk("t5_count0", count, 0);
        chk("t5_empty", empty, 1'b1);
        wr_valid = 3'b111;
        #1;
        chk("t5_rr_ready", wr_ready, 3'b010);
        cyc();
        wr_valid = '0;
        chk("t5_ch", ch, 1);
        chk("t5_count1", count, 1);

`ifdef CMDQ_STATS_EN
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
        for (int k = 0; k < 8; k++) begin
            wr_valid = 3'b001;
            wr_data[15:0] = WIDTH'(k);
            cyc();
        end
        wr_valid = 3'b100;
        repeat (10) cyc();
        wr_valid = '0;
        chk("t6_stall2", stall_cnt[32 +: 16], 10);
        chk("t6_hwm", hwm, 8);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        chk("t6_hwm_flush", hwm, 0);
        chk("t6_stall_kept", stall_cnt[32 +: 16], 10);
`endif

        // random traffic with phases biased toward filling, balanced, draining
        for (int n = 0; n < 4000; n++) begin
            int rp;
            rp = ((n / 200) % 3 == 0) ? 20 : ((n / 200) % 3 == 1) ? 50 : 85;
            rstn     = ($urandom_range(0, 299) != 0);
            flush    = ($urandom_range(0, 59) == 0);
            read     = ($urandom_range(0, 99) < rp);
            wr_valid = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) wr_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
            cyc();
        end
        rstn = 1'b1; flush = 1'b0; read = 1'b0; wr_valid = '0;
        cyc();
        checking = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
